// File: rtl/udm_pkg.sv
// Shared helpers for the UDM scheduler: operand-size arithmetic, legal UDM
// sizes and requester-ID width derivation.
package udm_pkg;

    localparam int NREQ_MIN = 2;
    localparam int NREQ_MAX = 16;

    // The UDM instance is sized by the wider of the two operands.
    function automatic int max_bw(input int dw, input int ww);
        return (dw > ww) ? dw : ww;
    endfunction

    // UDM only exists in power-of-two sizes from 2 to 32 bits.
    function automatic bit legal_bw(input int bw);
        return (bw == 2) || (bw == 4) || (bw == 8) || (bw == 16) || (bw == 32);
    endfunction

    // Requester ID width; never narrower than one bit.
    function automatic int id_width(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/udm_rr_grant.sv
// Round-robin priority encoder: picks the first asserted request at or after
// ptr, wrapping modulo NREQ. Purely combinational.
module udm_rr_grant
    import udm_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            any
);

    logic [2*NREQ-1:0] req_dbl;
    logic [2*NREQ-1:0] req_shift;
    logic [NREQ-1:0]   req_rot;
    logic [IDW-1:0]    offset;
    logic [IDW:0]      idx_sum;

    // Rotate the request vector so that position 0 is the current pointer.
    assign req_dbl   = {req, req};
    assign req_shift = req_dbl >> ptr;
    assign req_rot   = req_shift[NREQ-1:0];

    // Lowest set bit of the rotated vector, mapped back to a requester index.
    always_comb begin
        // NOTE: combinational logic uses blocking assignments so later loop
        // iterations see the updated 'any' and every output has a default.
        any       = 1'b0;
        offset    = '0;
        grant     = '0;
        grant_idx = '0;
        idx_sum   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!any && req_rot[k]) begin
                any    = 1'b1;
                offset = IDW'(k);
            end
        end
        idx_sum = {1'b0, ptr} + {1'b0, offset};
        if (idx_sum >= (IDW+1)'(NREQ)) begin
            idx_sum = idx_sum - (IDW+1)'(NREQ);
        end
        grant_idx = idx_sum[IDW-1:0];
        if (any) begin
            grant = NREQ'(1) << grant_idx;
        end
    end

endmodule

// File: rtl/udm_rr_scheduler.sv
// Shares one UDM multiplier among NREQ requesters. Round-robin arbitration
// feeds a two-stage pipeline: operand register (S1) -> UDM -> result register (S2).
module udm_rr_scheduler
    import udm_pkg::*;
#(
    parameter  int DW   = 8,
    parameter  int WW   = 8,
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*DW-1:0] req_a,
    input  logic [NREQ*WW-1:0] req_b,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [IDW-1:0]     res_id,
    output logic [DW+WW-1:0]   res_r
);

    localparam int BW = max_bw(DW, WW);
    localparam int PW = DW + WW;

    // Reject parameter sets the UDM or the ID encoding cannot support.
    generate
        if (!legal_bw(BW)) begin : g_bad_bw
            $error("udm_rr_scheduler: max(DW,WW)=%0d is not a legal UDM size", BW);
        end
        if ((NREQ < NREQ_MIN) || (NREQ > NREQ_MAX)) begin : g_bad_nreq
            $error("udm_rr_scheduler: NREQ=%0d outside 2..16", NREQ);
        end
    endgenerate

    logic            s1_v;
    logic [DW-1:0]   s1_a;
    logic [WW-1:0]   s1_b;
    logic [IDW-1:0]  s1_id;
    logic            s2_v;
    logic [IDW-1:0]  rr_ptr;

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            any;
    logic            s2_load;
    logic            s1_free;
    logic            accept;
    logic [DW-1:0]   sel_a;
    logic [WW-1:0]   sel_b;

    logic [BW-1:0]   udm_a;
    logic [BW-1:0]   udm_b;
    logic [2*BW-1:0] udm_p;
    logic [PW-1:0]   udm_r;

    udm_rr_grant #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_grant (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any)
    );

    // S1 empties whenever its content moves on to S2 in the same cycle.
    assign s2_load   = s1_v && (!s2_v || res_ready);
    assign s1_free   = !s1_v || s2_load;
    assign accept    = any && s1_free;
    assign req_ready = (s1_free && rst_n) ? grant : '0;
    assign res_valid = s2_v;

    // One-hot operand mux selecting the granted requester's operands.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_a = req_a[i*DW +: DW];
                sel_b = req_b[i*WW +: WW];
            end
        end
    end

    // UDM datapath: operands zero-extended to the UDM size; the product of a
    // DW-bit and a WW-bit value always fits in DW+WW bits.
    assign udm_a = BW'(s1_a);
    assign udm_b = BW'(s1_b);
    assign udm_p = udm_a * udm_b;
    assign udm_r = udm_p[PW-1:0];

    // Operand stage and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: data registers are reset too so res_r/res_id read zero after
        // reset; sequential state is always updated with non-blocking '<='.
        if (!rst_n) begin
            s1_v   <= 1'b0;
            s1_a   <= '0;
            s1_b   <= '0;
            s1_id  <= '0;
            rr_ptr <= '0;
        end else if (accept) begin
            s1_v   <= 1'b1;
            s1_a   <= sel_a;
            s1_b   <= sel_b;
            s1_id  <= grant_idx;
            rr_ptr <= (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
        end else if (s2_load) begin
            s1_v <= 1'b0;
        end
    end

    // Result stage: load from S1, or drain when the consumer takes the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v   <= 1'b0;
            res_r  <= '0;
            res_id <= '0;
        end else if (s2_load) begin
            s2_v   <= 1'b1;
            res_r  <= udm_r;
            res_id <= s1_id;
        end else if (res_ready) begin
            s2_v <= 1'b0;
        end
    end

endmodule

// File: tb/tb_udm_rr_scheduler.sv
// Self-checking bench for udm_rr_scheduler: a transaction-level model
// (in-flight queue, round-robin pointer) checked every cycle, plus directed
// scenarios with hand-computed expectations and a randomized phase.
module tb_udm_rr_scheduler;

    localparam int DW   = 8;
    localparam int WW   = 8;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*DW-1:0] req_a;
    logic [NREQ*WW-1:0] req_b;
    logic               res_valid;
    logic               res_ready;
    logic [IDW-1:0]     res_id;
    logic [DW+WW-1:0]   res_r;

    logic [DW-1:0] a_arr [NREQ];
    logic [WW-1:0] b_arr [NREQ];

    int checks = 0;
    int errors = 0;

    udm_rr_scheduler #(
        .DW   (DW),
        .WW   (WW),
        .NREQ (NREQ)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_r     (res_r)
    );

    always #5 clk = ~clk;

    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*DW +: DW] = a_arr[i];
            req_b[i*WW +: WW] = b_arr[i];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: products in flight in acceptance order, with age in cycles.
    typedef struct {
        int id;
        int prod;
        int age;
    } item_t;

    item_t           q[$];
    int              m_ptr = 0;
    logic [NREQ-1:0] acc_vec = '0;

    always @(negedge clk) begin : compare
        logic            exp_valid;
        logic            free;
        int              g;
        int              idx;
        logic [NREQ-1:0] exp_ready;
        item_t           it;
        if (!rst_n) begin
            q.delete();
            m_ptr   = 0;
            acc_vec = '0;
            check("rst_res_valid", res_valid, 0);
            check("rst_res_r", res_r, 0);
            check("rst_res_id", res_id, 0);
            check("rst_req_ready", req_ready, 0);
        end else begin
            // The oldest product is presented once it has spent two cycles inside.
            exp_valid = (q.size() > 0) && (q[0].age >= 2);
            check("res_valid", res_valid, exp_valid);
            if (exp_valid) begin
                check("res_id", res_id, q[0].id);
                check("res_r", res_r, q[0].prod);
            end
            // Two slots; a full pipeline accepts only while the head drains.
            free = (q.size() < 2) || res_ready;
            g = -1;
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_ptr + k) % NREQ;
                if (g < 0 && req_valid[idx]) g = idx;
            end
            exp_ready = '0;
            if (free && g >= 0) exp_ready[g] = 1'b1;
            check("req_ready", req_ready, exp_ready);
            acc_vec = exp_ready & req_valid;
            if (exp_valid && res_ready) q.delete(0);
            for (int j = 0; j < q.size(); j++) q[j].age++;
            if (acc_vec != '0) begin
                it.id   = g;
                it.prod = int'(a_arr[g]) * int'(b_arr[g]);
                it.age  = 1;
                q.push_back(it);
                m_ptr = (g + 1) % NREQ;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = '0;
        step();
        rst_n = 1'b0;
        @(negedge clk);
        step();
        rst_n = 1'b1;
    endtask

    // Issue one request, hold it until accepted, then wait for its result.
    task automatic send_one(input int id, input logic [7:0] a, input logic [7:0] b,
                            input string name, output logic [15:0] r);
        int n;
        bit done;
        r = '0;
        a_arr[id] = a;
        b_arr[id] = b;
        req_valid = '0;
        req_valid[id] = 1'b1;
        done = 1'b0;
        for (n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            if (req_ready[id]) done = 1'b1;
            step();
        end
        req_valid = '0;
        if (!done) check({name, "_accept_timeout"}, 0, 1);
        done = 1'b0;
        for (n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            if (res_valid && res_id == IDW'(id)) begin
                r = res_r;
                done = 1'b1;
            end
            step();
        end
        if (!done) check({name, "_result_timeout"}, 0, 1);
    endtask

    logic [15:0] r;
    logic [15:0] p1_first;

    initial begin
        req_valid = '0;
        res_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            a_arr[i] = '0;
            b_arr[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: single request, two-cycle latency, 13*11.
        a_arr[0] = 8'd13;
        b_arr[0] = 8'd11;
        req_valid = 4'b0001;
        @(negedge clk);
        check("t1_ready", req_ready, 4'b0001);
        step();
        req_valid = '0;
        @(negedge clk);
        check("t1_not_yet", res_valid, 0);
        step();
        @(negedge clk);
        check("t1_valid", res_valid, 1);
        check("t1_r", res_r, 16'd143);
        check("t1_id", res_id, 0);
        step();

        // 2: all valid from pointer 0 -> grants 0,1,2,3,0.
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            a_arr[i] = 8'(i + 2);
            b_arr[i] = 8'(i + 10);
        end
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t2_grant", req_ready, 4'b0001 << (k % 4));
            step();
        end
        req_valid = '0;
        repeat (4) step();

        // 3: backpressure with req1/req2 (pointer now 1).
        res_ready = 1'b0;
        a_arr[1] = 8'd7;
        b_arr[1] = 8'd9;
        a_arr[2] = 8'd20;
        b_arr[2] = 8'd30;
        p1_first = 16'd63;
        req_valid = 4'b0110;
        @(negedge clk);
        check("t3_c0_ready", req_ready, 4'b0010);
        step();
        a_arr[1] = 8'd5;
        b_arr[1] = 8'd6;
        @(negedge clk);
        check("t3_c1_ready", req_ready, 4'b0100);
        step();
        req_valid = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t3_stall_ready", req_ready, 4'b0000);
            check("t3_stall_valid", res_valid, 1);
            check("t3_stall_id", res_id, 1);
            check("t3_stall_r", res_r, p1_first);
            step();
        end
        res_ready = 1'b1;
        @(negedge clk);
        check("t3_rel_id", res_id, 1);
        check("t3_rel_ready", req_ready, 4'b0010);
        step();
        req_valid = '0;
        @(negedge clk);
        check("t3_second_valid", res_valid, 1);
        check("t3_second_id", res_id, 2);
        check("t3_second_r", res_r, 16'd600);
        step();
        @(negedge clk);
        check("t3_third_id", res_id, 1);
        check("t3_third_r", res_r, 16'd30);
        step();
        repeat (2) step();

        // 4: operand extremes.
        send_one(0, 8'hFF, 8'hFF, "t4_max", r);
        check("t4_max_r", r, 16'hFE01);
        send_one(3, 8'h00, 8'h5A, "t4_zero", r);
        check("t4_zero_r", r, 16'h0000);

        // 5: reset with S1 and S2 both occupied (pointer now 0).
        res_ready = 1'b0;
        a_arr[0] = 8'd3;
        b_arr[0] = 8'd4;
        a_arr[1] = 8'd5;
        b_arr[1] = 8'd6;
        req_valid = 4'b0011;
        step();
        step();
        #1;
        check("t5_pre_valid", res_valid, 1);
        check("t5_pre_full", req_ready, 4'b0000);
        req_valid = '0;
        rst_n = 1'b0;
        #1;
        check("t5_async_valid", res_valid, 0);
        @(negedge clk);
        step();
        rst_n = 1'b1;
        res_ready = 1'b1;
        a_arr[0] = 8'd21;
        b_arr[0] = 8'd3;
        a_arr[3] = 8'd12;
        b_arr[3] = 8'd12;
        req_valid = 4'b1001;
        @(negedge clk);
        check("t5_ptr_zero", req_ready, 4'b0001);
        step();
        req_valid = 4'b1000;
        @(negedge clk);
        check("t5_next", req_ready, 4'b1000);
        step();
        req_valid = '0;
        @(negedge clk);
        check("t5_r0_id", res_id, 0);
        check("t5_r0_r", res_r, 16'd63);
        step();
        @(negedge clk);
        check("t5_r3_id", res_id, 3);
        check("t5_r3_r", res_r, 16'd144);
        step();
        repeat (2) step();

        // 6: req3 alone wraps pointer to 0; then req0 beats req3.
        req_valid = 4'b1000;
        @(negedge clk);
        check("t6_first", req_ready, 4'b1000);
        step();
        req_valid = 4'b1001;
        @(negedge clk);
        check("t6_req0_first", req_ready, 4'b0001);
        step();
        req_valid = 4'b1000;
        @(negedge clk);
        check("t6_req3_then", req_ready, 4'b1000);
        step();
        req_valid = '0;
        repeat (4) step();

        // Random phase: requesters hold valid until accepted; random backpressure.
        for (int c = 0; c < 3000; c++) begin
            step();
            req_valid = req_valid & ~acc_vec;
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 99) < 40) begin
                    a_arr[i] = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
                    b_arr[i] = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
                    req_valid[i] = 1'b1;
                end
            end
            res_ready = ($urandom_range(0, 99) < 70);
        end
        step();
        req_valid = '0;
        res_ready = 1'b1;
        repeat (6) step();
        @(negedge clk);
        check("drain_valid", res_valid, 0);
        check("drain_model", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
